// File: rtl/ctr_pkg.sv
// Shared constants for the counter primitives: count direction and limit mode.
package ctr_pkg;

  localparam logic CTR_UP   = 1'b1;
  localparam logic CTR_DOWN = 1'b0;

  localparam int CTR_WRAP = 0;
  localparam int CTR_SAT  = 1;

endpackage : ctr_pkg

// File: rtl/toggle_cell.sv
// One counter bit: async clear, then direct set, then toggle.
module toggle_cell (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  input  logic set_en,
  input  logic set_val,
  output logic q
);

  logic r_q;

  // Bit state: direct-set path overrides the toggle enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 1'b0;
    end else if (set_en) begin
      r_q <= set_val;
    end else if (tog) begin
      r_q <= ~r_q;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule : toggle_cell

// File: rtl/tff_counter.sv
// Parametrised up/down modulus counter built from toggle cells with a carry/borrow chain,
// wrap or saturate at the limits, cascade terminal count and sticky overflow.
module tff_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = CTR_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic             SAT_MODE = (SATURATE == CTR_SAT);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_low_ones;
  logic [WIDTH-1:0] w_low_zeros;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_set_val;
  logic             w_set_en;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_limit;
  logic             r_ovf;

  assign w_at_max = (w_q == MAX_Q);
  assign w_at_min = (w_q == {WIDTH{1'b0}});
  assign w_limit  = en & ((up == CTR_UP) ? w_at_max : w_at_min);

  // Carry/borrow chain: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    w_low_ones     = {WIDTH{1'b0}};
    w_low_zeros    = {WIDTH{1'b0}};
    w_low_ones[0]  = 1'b1;
    w_low_zeros[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_low_ones[i]  = w_low_ones[i-1] & w_q[i-1];
      w_low_zeros[i] = w_low_zeros[i-1] & ~w_q[i-1];
    end
    w_tog = {WIDTH{en}} & ((up == CTR_UP) ? w_low_ones : w_low_zeros);
  end

  // Direct-set path for clear, clamped load and the limit value
  always_comb begin
    w_set_en  = 1'b0;
    w_set_val = {WIDTH{1'b0}};
    if (clr) begin
      w_set_en  = 1'b1;
      w_set_val = {WIDTH{1'b0}};
    end else if (load) begin
      w_set_en  = 1'b1;
      w_set_val = ({1'b0, d} < MOD_W) ? d : MAX_Q;
    end else if (w_limit) begin
      w_set_en  = 1'b1;
      if (SAT_MODE) begin
        w_set_val = w_q;
      end else begin
        w_set_val = (up == CTR_UP) ? {WIDTH{1'b0}} : MAX_Q;
      end
    end else begin
      w_set_en  = 1'b0;
      w_set_val = {WIDTH{1'b0}};
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    toggle_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .tog     (w_tog[g]),
      .set_en  (w_set_en),
      .set_val (w_set_val[g]),
      .q       (w_q[g])
    );
  end

  // Sticky overflow: set by any wrap or saturating hold, cleared only by clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (load) begin
      r_ovf <= r_ovf;
    end else if (w_limit) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign q     = w_q;
  assign q_not = ~w_q;
  assign tc    = w_limit;
  assign ovf   = r_ovf;

endmodule : tff_counter

// File: doc/tff_counter.md
# tff_counter

Parametrised synchronous up/down counter built from a bank of toggle cells, one per bit, with a carry/borrow chain generating each cell's toggle enable. Successor to the single toggle flip-flop. Adds programmable width and modulus, direction control, parallel load, synchronous clear, wrap or saturate mode, a cascade terminal-count output and a sticky overflow flag. Serves as the general counter primitive for the timer and divider blocks.

## Interface
- `WIDTH`, 4: counter width in bits, at least 1.
- `MODULUS`, 2**WIDTH: count range is 0..MODULUS-1. Must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- `SATURATE`, 0: 0 means wrap at the limits; 1 means hold at the limits.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear.
- `load`  in  1  synchronous parallel load.
- `d`  in  WIDTH  load value.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `q`  out  WIDTH  count value (registered).
- `q_not`  out  WIDTH  bitwise complement of `q`.
- `tc`  out  1  terminal count (combinational, used for cascading).
- `ovf`  out  1  sticky overflow flag (registered).

## Operation
- **Reset.** `reset`=0 forces `q`=0 and `ovf`=0 immediately, independent of `clk`. As a result `q_not` is all ones and `tc` is 0 unless `en`=1 and `up`=0.
- **Per-edge priority:** `clr` > `load` > `en`. When none of them is asserted, `q` holds.
- **clr:** `q` becomes 0 and `ovf` becomes 0.
- **load:** `q` becomes `d` if `d` < MODULUS; otherwise `q` becomes MODULUS-1. `ovf` is unchanged.
- **en with up=1:**
  - If `q` < MODULUS-1, `q` becomes `q`+1.
  - If `q` = MODULUS-1: with SATURATE=0, `q` wraps to 0; with SATURATE=1, `q` holds. In both cases `ovf` becomes 1.
- **en with up=0:**
  - If `q` > 0, `q` becomes `q`-1.
  - If `q` = 0: with SATURATE=0, `q` wraps to MODULUS-1; with SATURATE=1, `q` holds. In both cases `ovf` becomes 1.
- **tc** = `en` & (`up` ? `q`==MODULUS-1 : `q`==0). It is gated by `en` only, not by `clr` or `load`.
- **Non-power-of-two modulus.** The wrap value is forced explicitly; the next-state logic does not rely on natural binary rollover.
- **Toggle cells.** Each bit toggles when its toggle enable is 1:
  - up: enable = `en` & (all lower bits are 1);
  - down: enable = `en` & (all lower bits are 0).
- **Limit handling.** At a limit, and for load and clear, the cells are driven by a direct-set path rather than by toggling.
- **Width rules.** Comparisons are unsigned at WIDTH bits. No intermediate result is wider than WIDTH+1 bits.

## Timing
- Count, load and clear each take effect in one cycle: `q` updates on the same rising edge at which the control was sampled.
- `ovf` sets on the edge that performs the wrap or saturating hold, and is visible in the following cycle.
- `tc` is combinational from `q`, `en` and `up`, with zero latency. When cascading, drive the next stage's `en` from this stage's `tc`.
- **Direction change:** a change of `up` between edges is legal. The new direction applies at the next edge.
- **Reset mid-count:** asserting `reset` clears the counter immediately. Deasserting it near a clock edge is the system's responsibility. The first count occurs on the first edge at which `reset`=1 and `en`=1.

## Structure
- Shared package `ctr_pkg` holds:
  - the direction constants `CTR_UP`=1 and `CTR_DOWN`=0;
  - the mode constants `CTR_WRAP`=0 and `CTR_SAT`=1.
- Sub-module `toggle_cell`: one bit, with inputs `clk`, `reset`, `tog`, `set_en` and `set_val`, and output `q`.
  - Priority inside the cell: reset first, then `set_en` loads `set_val`, then `tog` inverts the bit.
  - The top level instantiates WIDTH cells in a generate loop.
  - The top level holds the carry/borrow chain, the limit detection, `tc` and `ovf`.

## Test plan
All scenarios use WIDTH=4 and MODULUS=10 unless stated otherwise.

- **Reset.** Pulse `reset` low for 3 ns mid-cycle while `q`=7. Required: `q`=0, `q_not`=4'hF and `ovf`=0 before the next edge.
- **Up wrap** (SATURATE=0). `en`=1, `up`=1 for 12 edges from 0. Required: `q` goes 1..9, then 0, then 1, 2. `tc`=1 only while `q`=9. `ovf`=1 from the cycle after the wrap.
- **Down saturate** (SATURATE=1). Load 2, then `en`=1, `up`=0 for 4 edges. Required: `q` = 1, 0, 0, 0. `tc`=1 while `q`=0. `ovf` sets after the first held edge.
- **Priority.** With `q`=5, assert `clr`, `load` (`d`=3) and `en` on the same edge. Required: `q`=0 and `ovf`=0. Next, assert `load` (`d`=3) and `en` together. Required: `q`=3.
- **Out-of-range load.** `d`=4'd13. Required: `q`=9.
- **Cascade.** Two instances (WIDTH=4, MODULUS=10), with the second stage's `en` driven by the first stage's `tc`. Run 100 edges up from 0/0. Required: the combined decimal value goes 00 → 99 → 00. The high stage's `ovf` sets on the 100th edge.
